// File: rtl/neq_sched_pkg.sv
// Shared types for the neq_sched comparator scheduler.
// Holds the FSM state encoding, the index-width helper and the requester index type.
package neq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Largest supported requester count; the index type is sized for it so that
  // every instance shares one index type regardless of N.
  localparam int MAX_N = 16;

  // Index width for n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_width(MAX_N);

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/neq_sched_rr_pick.sv
// Combinational round-robin picker: chooses the first set request at or after ptr,
// wrapping from N-1 back to 0. Produces one-hot grant, grant index and an any flag.
module rr_pick
  import neq_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  idx_t         ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output idx_t         gnt_idx_o,
  output logic         any_o
);

  int best_dist_s;
  int dist_s;

  // Select the requester with the smallest circular distance from ptr.
  always_comb begin
    best_dist_s = N;
    dist_s      = 0;
    gnt_idx_o   = '0;
    gnt_oh_o    = '0;
    any_o       = 1'b0;
    for (int i = 0; i < N; i++) begin
      dist_s = (i >= int'(ptr_i)) ? (i - int'(ptr_i)) : (i + N - int'(ptr_i));
      if (req_i[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        gnt_idx_o   = idx_t'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    any_o = (best_dist_s < N);
    for (int i = 0; i < N; i++) begin
      gnt_oh_o[i] = any_o && (gnt_idx_o == idx_t'(i));
    end
  end

endmodule

// File: rtl/neq_sched.sv
// neq_sched: round-robin scheduler sharing one inequality comparator among N requesters.
// Flow per operation: IDLE (arbitrate + latch operands) -> BUSY (drive comparator,
// wait for its result) -> RESP (return result to the granted requester).
// Optional build macro NEQ_SCHED_STATS_EN adds saturating stat_ops / stat_neq counters.
module neq_sched
  import neq_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic           rsp_data,
  output logic           cmp_din0_valid,
  input  logic           cmp_din0_ready,
  output logic [W-1:0]   cmp_din0_data,
  output logic           cmp_din1_valid,
  input  logic           cmp_din1_ready,
  output logic [W-1:0]   cmp_din1_data,
  input  logic           cmp_dout_valid,
  output logic           cmp_dout_ready,
  input  logic           cmp_dout_data
`ifdef NEQ_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_neq
`endif
);

  if ((N < 2) || (N > MAX_N) || (CNT_W < 1)) begin : g_param_check
    $error("neq_sched: N must be 2..16 and CNT_W at least 1");
  end

  state_e         state_q, state_d;
  idx_t           ptr_q, ptr_d;
  idx_t           gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           res_q, res_d;

  logic [N-1:0]   pick_oh_s;
  idx_t           pick_idx_s;
  logic           pick_any_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic [N-1:0]   gnt_dec_s;
  logic           rsp_hs_s;

  // The din readies are implied by the dout handshake of the comparator protocol.
  logic           unused_ready_s;
  assign unused_ready_s = cmp_din0_ready ^ cmp_din1_ready;

  rr_pick #(.N(N)) u_rr_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh_s),
    .gnt_idx_o (pick_idx_s),
    .any_o     (pick_any_s)
  );

  // Operand mux for the requester the picker selected; decode of the held grant.
  always_comb begin
    sel_a_s   = '0;
    sel_b_s   = '0;
    gnt_dec_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_a_s      = sel_a_s | (req_a[i*W +: W] & {W{pick_oh_s[i]}});
      sel_b_s      = sel_b_s | (req_b[i*W +: W] & {W{pick_oh_s[i]}});
      gnt_dec_s[i] = (gnt_q == idx_t'(i));
    end
    rsp_hs_s = (state_q == RESP) && ((rsp_ready & gnt_dec_s) != '0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pointer, grant, latched operands and captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      gnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  // Next-state and register-update logic; each register changes only in its own state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = BUSY;
          gnt_d   = pick_idx_s;
          a_d     = sel_a_s;
          b_d     = sel_b_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cmp_dout_valid) begin
          state_d = RESP;
          res_d   = cmp_dout_data;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == idx_t'(N - 1)) ? '0 : (gnt_q + idx_t'(1));
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state; req_ready is forced low while in reset.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    cmp_din0_valid = 1'b0;
    cmp_din1_valid = 1'b0;
    cmp_dout_ready = 1'b0;
    cmp_din0_data  = a_q;
    cmp_din1_data  = b_q;
    rsp_data       = res_q;
    case (state_q)
      IDLE: begin
        if (rst) begin
          req_ready = pick_oh_s;
        end else begin
          req_ready = '0;
        end
      end
      BUSY: begin
        cmp_din0_valid = 1'b1;
        cmp_din1_valid = 1'b1;
        cmp_dout_ready = 1'b1;
      end
      RESP: begin
        rsp_valid = gnt_dec_s;
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

`ifdef NEQ_SCHED_STATS_EN
  logic [CNT_W-1:0] stat_ops_q;
  logic [CNT_W-1:0] stat_neq_q;

  // Saturating counters of completed responses and of responses reporting a difference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops_q <= '0;
      stat_neq_q <= '0;
    end else if (rsp_hs_s) begin
      if (stat_ops_q != '1) begin
        stat_ops_q <= stat_ops_q + CNT_W'(1);
      end else begin
        stat_ops_q <= stat_ops_q;
      end
      if (res_q && (stat_neq_q != '1)) begin
        stat_neq_q <= stat_neq_q + CNT_W'(1);
      end else begin
        stat_neq_q <= stat_neq_q;
      end
    end else begin
      stat_ops_q <= stat_ops_q;
      stat_neq_q <= stat_neq_q;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_neq = stat_neq_q;
`endif

endmodule

// File: tb/tb_neq_sched.sv
// Directed, table-driven bench for neq_sched (N=4, W=16).
module tb_neq_sched;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic           rsp_data;
  logic           cmp_din0_valid, cmp_din0_ready;
  logic [W-1:0]   cmp_din0_data;
  logic           cmp_din1_valid, cmp_din1_ready;
  logic [W-1:0]   cmp_din1_data;
  logic           cmp_dout_valid, cmp_dout_ready, cmp_dout_data;
  logic           cmp_en;
`ifdef NEQ_SCHED_STATS_EN
  logic [CNT_W-1:0] stat_ops, stat_neq;
`endif

  neq_sched #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .cmp_din0_valid (cmp_din0_valid),
    .cmp_din0_ready (cmp_din0_ready),
    .cmp_din0_data  (cmp_din0_data),
    .cmp_din1_valid (cmp_din1_valid),
    .cmp_din1_ready (cmp_din1_ready),
    .cmp_din1_data  (cmp_din1_data),
    .cmp_dout_valid (cmp_dout_valid),
    .cmp_dout_ready (cmp_dout_ready),
    .cmp_dout_data  (cmp_dout_data)
`ifdef NEQ_SCHED_STATS_EN
    ,
    .stat_ops       (stat_ops),
    .stat_neq       (stat_neq)
`endif
  );

  always #5 clk = ~clk;

  // Comparator model: always ready on inputs, answers in the same cycle when enabled.
  assign cmp_din0_ready = 1'b1;
  assign cmp_din1_ready = 1'b1;
  assign cmp_dout_valid = cmp_din0_valid & cmp_din1_valid & cmp_en;
  assign cmp_dout_data  = (cmp_din0_data != cmp_din1_data);

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;
  int exp_neq  = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    int          g;
    int          cst;
    int          rst_stall;
    logic        exp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester i sees base + i*0x1000, so a wrong operand mux shows up on din data.
  function automatic logic [N*W-1:0] pack_ops(input logic [15:0] base);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + 16'(i) * 16'h1000;
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    logic [N-1:0] oh;
    logic [15:0]  ea, eb;
    oh = 4'b0001 << v.g;
    ea = v.a + 16'(v.g) * 16'h1000;
    eb = v.b + 16'(v.g) * 16'h1000;
    req_valid = v.mask;
    req_a     = pack_ops(v.a);
    req_b     = pack_ops(v.b);
    cmp_en    = (v.cst == 0);
    rsp_ready = '0;
    #1;
    chk("accept_ready", 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    chk("busy_valids", 64'({cmp_din0_valid, cmp_din1_valid, cmp_dout_ready}), 64'(3'b111));
    chk("busy_din0", 64'(cmp_din0_data), 64'(ea));
    chk("busy_din1", 64'(cmp_din1_data), 64'(eb));
    chk("busy_no_rsp", 64'(rsp_valid), 64'(0));
    chk("busy_no_ready", 64'(req_ready), 64'(0));
    for (int s = 1; s < v.cst; s++) begin
      @(posedge clk); #1;
      chk("stall_din0", 64'(cmp_din0_data), 64'(ea));
      chk("stall_din1", 64'(cmp_din1_data), 64'(eb));
      chk("stall_no_rsp", 64'(rsp_valid), 64'(0));
    end
    cmp_en    = 1'b1;
    rsp_ready = (v.rst_stall == 0) ? oh : ~oh;
    @(posedge clk); #1;
    chk("resp_valid", 64'(rsp_valid), 64'(oh));
    chk("resp_data", 64'(rsp_data), 64'(v.exp));
    chk("resp_no_ready", 64'(req_ready), 64'(0));
    for (int s = 1; s < v.rst_stall; s++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_hold_no_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    chk("idle_rsp_clear", 64'(rsp_valid), 64'(0));
    rsp_ready = '0;
    exp_ops++;
    if (v.exp) exp_neq++;
  endtask

  initial begin
    vec_t rv;
    // mask, a, b, expected grant, comparator stall, response stall, expected result
    vt[0]  = '{4'b0001, 16'h1234, 16'h1234, 0, 0, 0, 1'b0};
    vt[1]  = '{4'b0001, 16'h1234, 16'h1235, 0, 0, 0, 1'b1};
    vt[2]  = '{4'b1000, 16'hAAAA, 16'h5555, 3, 0, 0, 1'b1};
    vt[3]  = '{4'b1111, 16'h0000, 16'h0000, 0, 0, 0, 1'b0};
    vt[4]  = '{4'b1111, 16'h0F0F, 16'h0F0E, 1, 0, 0, 1'b1};
    vt[5]  = '{4'b1111, 16'h8000, 16'h8000, 2, 0, 0, 1'b0};
    vt[6]  = '{4'b1111, 16'h0001, 16'h0000, 3, 0, 0, 1'b1};
    vt[7]  = '{4'b1111, 16'h4321, 16'h4321, 0, 0, 0, 1'b0};
    vt[8]  = '{4'b0100, 16'h0BAD, 16'h0BAD, 2, 0, 0, 1'b0};
    vt[9]  = '{4'b1001, 16'h1111, 16'h2222, 3, 0, 0, 1'b1};
    vt[10] = '{4'b1001, 16'h3333, 16'h3333, 0, 0, 0, 1'b0};
    vt[11] = '{4'b0010, 16'h7777, 16'h7778, 1, 5, 0, 1'b1};
    vt[12] = '{4'b0010, 16'h6666, 16'h6666, 1, 0, 4, 1'b0};
    vt[13] = '{4'b0110, 16'h0123, 16'h0124, 2, 0, 0, 1'b1};

    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    cmp_en    = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_cmp_valid", 64'({cmp_din0_valid, cmp_din1_valid, cmp_dout_ready}), 64'(0));
    chk("rst_din0", 64'(cmp_din0_data), 64'(0));
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    #1;
    chk("idle_no_req", 64'(req_ready), 64'(0));

    for (int k = 0; k < 14; k++) run_op(vt[k]);

`ifdef NEQ_SCHED_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'(exp_ops));
    chk("stat_neq", 64'(stat_neq), 64'(exp_neq));
`endif

    // Reset during BUSY: ptr is 3 here, so a lingering ptr would grant 3 afterwards.
    req_valid = 4'b1100;
    req_a     = pack_ops(16'h5A5A);
    req_b     = pack_ops(16'h5A5B);
    cmp_en    = 1'b0;
    #1;
    chk("pre_rst_grant", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(cmp_din0_valid), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_valids", 64'({cmp_din0_valid, cmp_din1_valid, cmp_dout_ready}), 64'(0));
    chk("mid_rst_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
    chk("mid_rst_din0", 64'(cmp_din0_data), 64'(0));
`ifdef NEQ_SCHED_STATS_EN
    chk("mid_rst_stats", 64'({stat_ops, stat_neq}), 64'(0));
`endif
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    rv = '{4'b1010, 16'h0055, 16'h0055, 1, 0, 0, 1'b0};
    run_op(rv);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
